// File: rtl/spread_engine_arbiter.sv
// Round-robin arbiter for the shared inter-month spread engine: grants a requester,
// sequences engine restart/run, watches for completion and returns the tagged TSC.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | engine held in reset, waiting for any requester
// CLEAR | engine held in reset for RST_CYCLES after a grant
// RUN   | engine enabled, watchdog counting until done or timeout
// RESP  | result presented, waiting for the consumer handshake
module spread_engine_arbiter #(
  parameter int NREQ       = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    eng_rst_n,
  input  logic                    eng_done,
  input  logic [15:0]             eng_tsc,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [15:0]             rsp_tsc,
  output logic                    rsp_timeout,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam int CW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            eng_rst_n_q, eng_rst_n_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_tsc_q, rsp_tsc_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [WW-1:0]   wdog_q, wdog_d;

  logic            found;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_d         = sel_q;
    req_ready_d   = '0;
    eng_rst_n_d   = eng_rst_n_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_tsc_d     = rsp_tsc_q;
    rsp_timeout_d = rsp_timeout_q;
    clr_cnt_d     = clr_cnt_q;
    wdog_d        = wdog_q;
    found         = 1'b0;
    winner        = '0;
    cand          = '0;

    // Search starts just after the last served requester and wraps.
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        eng_rst_n_d = 1'b0;
        if (found) begin
          sel_d       = winner;
          req_ready_d = NREQ'(1) << winner;
          clr_cnt_d   = CW'(RST_CYCLES - 1);
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == '0) begin
          eng_rst_n_d = 1'b1;
          wdog_d      = '0;
          state_d     = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        wdog_d = wdog_q + WW'(1);
        // Completion takes priority over a coincident watchdog expiry.
        if (eng_done) begin
          rsp_tsc_d     = eng_tsc;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = sel_q;
          state_d       = S_RESP;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          rsp_tsc_d     = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = sel_q;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = sel_q;
          eng_rst_n_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= IW'(NREQ - 1);
      sel_q         <= '0;
      req_ready_q   <= '0;
      eng_rst_n_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_tsc_q     <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      clr_cnt_q     <= '0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_q         <= sel_d;
      req_ready_q   <= req_ready_d;
      eng_rst_n_q   <= eng_rst_n_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_tsc_q     <= rsp_tsc_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      clr_cnt_q     <= clr_cnt_d;
      wdog_q        <= wdog_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign sel         = sel_q;
  assign eng_rst_n   = eng_rst_n_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_tsc     = rsp_tsc_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule
